// File: rtl/fix_div_sched.sv
// Round-robin scheduler sharing a single fix_div among NUM_REQ requesters.
// Optional: define DIV_ZERO_CHECK_EN to answer divisor==0 ops directly with an error.
module fix_div_sched #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*32-1:0] req_dividend,
  input  logic [NUM_REQ*32-1:0] req_divisor,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  div_start,
  output logic [32:0]           div_dividend,
  output logic [32:0]           div_divisor,
  input  logic                  div_complete,
  input  logic [32:0]           div_quotient
);

  localparam int unsigned DW    = 32;
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [DW-1:0] ERR_DATA = '1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d, gnt_q, gnt_d;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic [DW-1:0]      dvd_q, dvd_d, dvs_q, dvs_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [NUM_REQ-1:0] rsp_valid_d;
  logic [DW-1:0]      rsp_data_d;
  logic               rsp_err_d, busy_d, div_start_d;
  logic [DW-1:0]      dvd_arr [NUM_REQ];
  logic [DW-1:0]      dvs_arr [NUM_REQ];
  logic               unused_q0;

  assign unused_q0 = div_quotient[0];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign dvd_arr[i] = req_dividend[32*i +: 32];
    assign dvs_arr[i] = req_divisor[32*i +: 32];
  end

  assign div_dividend = {1'b0, dvd_q};
  assign div_divisor  = {1'b0, dvs_q};

  // First set request strictly after rr_q, wrapping; smallest offset wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((32'(rr_q) + k) % NUM_REQ);
      if (req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state and registered-output decode; tmr_q counts cycles since div_start.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    tmr_d       = tmr_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    div_start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          rr_d  = pick_idx;
          gnt_d = pick_idx;
          dvd_d = dvd_arr[pick_idx];
          dvs_d = dvs_arr[pick_idx];
          tmr_d = '0;
`ifdef DIV_ZERO_CHECK_EN
          if (dvs_arr[pick_idx] == '0) begin
            state_d               = S_RESP;
            rsp_valid_d[pick_idx] = 1'b1;
            rsp_data_d            = ERR_DATA;
            rsp_err_d             = 1'b1;
          end else begin
            state_d     = S_ISSUE;
            div_start_d = 1'b1;
          end
`else
          state_d     = S_ISSUE;
          div_start_d = 1'b1;
`endif
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        tmr_d   = tmr_q + TMR_W'(1);
      end
      S_WAIT: begin
        tmr_d = tmr_q + TMR_W'(1);
        // tmr_q==1 is the first WAIT cycle, where done may still be stale
        if (div_complete && (tmr_q != TMR_W'(1))) begin
          state_d            = S_RESP;
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_data_d         = div_quotient[32:1];
          rsp_err_d          = 1'b0;
        end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          state_d            = S_RESP;
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_data_d         = ERR_DATA;
          rsp_err_d          = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_q      <= IDX_W'(NUM_REQ - 1);
      gnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      tmr_q     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      div_start <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      tmr_q     <= tmr_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
      busy      <= busy_d;
      div_start <= div_start_d;
    end
  end

endmodule

// File: tb/tb_fix_div_sched.sv
// Scoreboard bench for fix_div_sched with a 34-cycle fix_div model.
module tb_fix_div_sched;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned TIMEOUT_CYC = 64;
  localparam int unsigned LAT         = 34;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ*32-1:0] req_dividend = '0;
  logic [NUM_REQ*32-1:0] req_divisor = '0;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_data;
  logic                  rsp_err;
  logic                  busy;
  logic                  div_start;
  logic [32:0]           div_dividend;
  logic [32:0]           div_divisor;
  logic                  div_complete;
  logic [32:0]           div_quotient;

  fix_div_sched #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_complete(div_complete), .div_quotient(div_quotient)
  );

  always #5 clk = ~clk;

  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // fix_div model: done rises LAT+1 cycles after the div_start cycle, stays stale one extra cycle after next start
  logic        use_prog = 1'b0;
  logic        hang = 1'b0;
  logic [32:0] prog_q = '0;
  logic [7:0]  m_cnt;
  logic        m_start_d;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= '0; m_start_d <= 1'b0; div_complete <= 1'b0; div_quotient <= '0;
    end else begin
      m_start_d <= div_start;
      if (div_start) m_cnt <= 8'(LAT);
      else if (m_cnt != 0) m_cnt <= m_cnt - 8'd1;
      if (m_start_d) div_complete <= 1'b0;
      if (m_cnt == 8'd1 && !hang) begin
        div_complete <= 1'b1;
        div_quotient <= use_prog ? prog_q : {div_dividend[31:0] ^ div_divisor[31:0], 1'b0};
      end
    end
  end

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] data;
    logic        err;
    logic [31:0] at;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned n_start = 0;
  int unsigned n_busy_lo = 0;
  logic        bmon = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] v, input logic [31:0] d, input logic e, input logic [31:0] at);
    exp_t x;
    x.vld = v; x.data = d; x.err = e; x.at = at;
    sb.push_back(x);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned i = 0;
    while (sb.size() != 0 && i < budget) begin
      tick(1);
      i++;
    end
    check("drain_timeout", 64'(sb.size()), 64'(0));
    sb.delete();
  endtask

  // Monitor: every response pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (div_start) n_start++;
    if (bmon && !busy) n_busy_lo++;
    if (rst_n && rsp_valid != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_valid), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        check("rsp_valid", 64'(rsp_valid), 64'(mon_e.vld));
        check("rsp_data", 64'(rsp_data), 64'(mon_e.data));
        check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
        check("rsp_cycle", 64'(cyc), 64'(mon_e.at));
      end
    end
  end

  initial begin : stim
    logic [31:0] g;
    logic [31:0] dv [4];
    logic [31:0] ds [4];
    logic [2:0]  order [5];
    order[0] = 3'd0; order[1] = 3'd1; order[2] = 3'd2; order[3] = 3'd3; order[4] = 3'd0;

    // Reset state
    tick(3);
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_div_start", 64'(div_start), 64'(0));
    check("rst_div_dividend", 64'(div_dividend), 64'(0));
    rst_n = 1'b1;
    tick(2);

    // Fairness: all four held, grants 0,1,2,3,0 every 38 cycles
    for (int i = 0; i < 4; i++) begin
      dv[i] = 32'h1111_1111 * (i + 1);
      ds[i] = 32'h0000_00F0 + 32'(i);
      req_dividend[32*i +: 32] = dv[i];
      req_divisor[32*i +: 32]  = ds[i];
    end
    n_start = 0;
    g = cyc;
    req = 4'b1111;
    for (int i = 0; i < 5; i++)
      push(4'(1) << order[i], dv[order[i]] ^ ds[order[i]], 1'b0, g + 37 + 38 * i);
    tick(1);
    bmon = 1'b1;
    tick(152);
    req = '0;
    tick(37);
    bmon = 1'b0;
    check("fair_busy_idle_gaps", 64'(n_busy_lo), 64'(4));
    drain(50);
    check("fair_div_starts", 64'(n_start), 64'(5));

    // Single op with programmed quotient
    use_prog = 1'b1;
    prog_q = 33'h1_0000_0001;
    n_start = 0;
    g = cyc;
    req = 4'b0001;
    push(4'b0001, 32'h8000_0000, 1'b0, g + 37);
    tick(1);
    req = '0;
    tick(37);
    check("single_valid_after", 64'(rsp_valid), 64'(0));
    check("single_data_hold", 64'(rsp_data), 64'h8000_0000);
    check("single_div_starts", 64'(n_start), 64'(1));
    drain(10);
    use_prog = 1'b0;

    // Operand sampling: dividend change after grant is ignored
    req_dividend[63:32] = 32'hCAFE_0001;
    req_divisor[63:32]  = 32'h0000_0003;
    g = cyc;
    req = 4'b0010;
    push(4'b0010, 32'hCAFE_0002, 1'b0, g + 37);
    tick(1);
    req_dividend[63:32] = 32'hDEAD_BEEF;
    req = '0;
    tick(1);
    check("sample_div_dividend", 64'(div_dividend), 64'h0_CAFE_0001);
    check("sample_div_divisor", 64'(div_divisor), 64'h0_0000_0003);
    tick(10);
    check("sample_hold_dividend", 64'(div_dividend), 64'h0_CAFE_0001);
    drain(60);

    // Timeout: divider never completes
    hang = 1'b1;
    g = cyc;
    req = 4'b0100;
    push(4'b0100, 32'hFFFF_FFFF, 1'b1, g + 1 + TIMEOUT_CYC);
    tick(1);
    req = '0;
    drain(100);
    hang = 1'b0;

    // Divide by zero on requester 3
    req_dividend[127:96] = 32'h0000_1234;
    req_divisor[127:96]  = 32'h0;
    n_start = 0;
    g = cyc;
    req = 4'b1000;
`ifdef DIV_ZERO_CHECK_EN
    push(4'b1000, 32'hFFFF_FFFF, 1'b1, g + 1);
`else
    push(4'b1000, 32'h0000_1234, 1'b0, g + 37);
`endif
    tick(1);
    req = '0;
    drain(60);
`ifdef DIV_ZERO_CHECK_EN
    check("dz_div_starts", 64'(n_start), 64'(0));
`else
    check("dz_div_starts", 64'(n_start), 64'(1));
`endif

    // Reset mid-WAIT, then a pending req[2] is served
    req_divisor[127:96] = 32'h0000_0005;
    req = 4'b1000;
    tick(1);
    req = '0;
    tick(9);
    rst_n = 1'b0;
    #1;
    check("rstmid_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rstmid_rsp_data", 64'(rsp_data), 64'(0));
    check("rstmid_rsp_err", 64'(rsp_err), 64'(0));
    check("rstmid_busy", 64'(busy), 64'(0));
    check("rstmid_div_start", 64'(div_start), 64'(0));
    check("rstmid_div_divisor", 64'(div_divisor), 64'(0));
    req_dividend[95:64] = 32'h0F0F_0000;
    req_divisor[95:64]  = 32'h0000_00FF;
    req = 4'b0100;
    tick(3);
    rst_n = 1'b1;
    g = cyc;
    push(4'b0100, 32'h0F0F_00FF, 1'b0, g + 37);
    tick(1);
    req = '0;
    drain(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
